// File: rtl/mod_counter_chain.sv
// mod_counter_chain: multi-digit modulo counter chain.
//
// Digit i counts modulo MAXV[i*W +: W] + 1. Digit 0 is least significant. The whole chain
// updates on a single clock edge and can count up or down. It supports synchronous clear
// and load, and gives registered one-cycle wrap pulses per digit and for the full chain.
//
// Optional feature macro: COUNTER_SATURATE_EN. When it is defined, the chain holds at its
// full-chain limit instead of wrapping, and carry reports every blocked step.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   en         in   count enable, one step per edge
//   up         in   1 = increment, 0 = decrement
//   clear      in   synchronous clear (highest synchronous priority)
//   load       in   synchronous parallel load, saturated per digit to MAXV
//   load_val   in   load data, packed like count
//   count      out  registered chain value
//   digit_wrap out  registered one-cycle pulse per digit that wrapped
//   carry      out  registered one-cycle pulse when the whole chain wrapped (or was blocked)
//   tc         out  combinational: every digit at its terminal value for the current up
module mod_counter_chain #(
  parameter int unsigned         DIGITS = 4,
  parameter int unsigned         W      = 4,
  parameter logic [DIGITS*W-1:0] MAXV   = {4'd5, 4'd9, 4'd5, 4'd9}
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                up,
  input  logic                clear,
  input  logic                load,
  input  logic [DIGITS*W-1:0] load_val,
  output logic [DIGITS*W-1:0] count,
  output logic [DIGITS-1:0]   digit_wrap,
  output logic                carry,
  output logic                tc
);

  logic [DIGITS*W-1:0] count_q, count_d;
  logic [DIGITS-1:0]   digit_wrap_q, digit_wrap_d;
  logic                carry_q, carry_d;
  logic [DIGITS-1:0]   at_term;
  logic                blocked;

  // A digit is terminal at MAXV when counting up and at 0 when counting down.
  always_comb begin : p_term
    for (int unsigned i = 0; i < DIGITS; i++) begin
      at_term[i] = (count_q[i*W +: W] == (up ? MAXV[i*W +: W] : {W{1'b0}}));
    end
  end

  assign tc = &at_term;

`ifdef COUNTER_SATURATE_EN
  assign blocked = tc;
`else
  assign blocked = 1'b0;
`endif

  always_comb begin : p_next
    logic         lower_term;
    logic [W-1:0] dig;
    logic [W-1:0] max_dig;
    count_d      = count_q;
    digit_wrap_d = '0;
    carry_d      = 1'b0;
    lower_term   = 1'b1;
    dig          = '0;
    max_dig      = '0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        dig     = load_val[i*W +: W];
        max_dig = MAXV[i*W +: W];
        count_d[i*W +: W] = (dig > max_dig) ? max_dig : dig;
      end
    end else if (en) begin
      if (blocked) begin
        // At the full-chain limit in saturating mode: hold and flag the blocked step.
        carry_d = 1'b1;
      end else begin
        carry_d = tc;
        for (int unsigned i = 0; i < DIGITS; i++) begin
          dig     = count_q[i*W +: W];
          max_dig = MAXV[i*W +: W];
          // A digit steps only when every lower digit is terminal.
          if (lower_term) begin
            digit_wrap_d[i] = at_term[i];
            if (up) begin
              count_d[i*W +: W] = at_term[i] ? {W{1'b0}} : dig + W'(1);
            end else begin
              count_d[i*W +: W] = at_term[i] ? max_dig : dig - W'(1);
            end
          end
          lower_term = lower_term & at_term[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q      <= '0;
      digit_wrap_q <= '0;
      carry_q      <= 1'b0;
    end else begin
      count_q      <= count_d;
      digit_wrap_q <= digit_wrap_d;
      carry_q      <= carry_d;
    end
  end

  assign count      = count_q;
  assign digit_wrap = digit_wrap_q;
  assign carry      = carry_q;

endmodule

// File: tb/tb_mod_counter_chain.sv
module tb_mod_counter_chain;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        up;
  logic        clear;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] count;
  logic [3:0]  digit_wrap;
  logic        carry;
  logic        tc;

  int n_checks = 0;
  int n_pass   = 0;

  mod_counter_chain dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .up         (up),
    .clear      (clear),
    .load       (load),
    .load_val   (load_val),
    .count      (count),
    .digit_wrap (digit_wrap),
    .carry      (carry),
    .tc         (tc)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle; inputs change here, away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; load_val = v;
    step();
    load = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b0; up = 1'b1; clear = 1'b0; load = 1'b0; load_val = '0;
    #1;
    n_checks++;
    if (count !== 16'h0000 || carry !== 1'b0 || digit_wrap !== 4'b0000)
      $display("FAIL reset_init: count=%h carry=%b wrap=%b expected 0000/0/0000",
               count, carry, digit_wrap);
    else n_pass++;
    #1 reset = 1'b1;
    do_load(16'h0347);
    n_checks++;
    if (count !== 16'h0347) $display("FAIL load_0347: count=%h expected 0347", count);
    else n_pass++;
    en = 1'b1;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (count !== 16'h0000 || carry !== 1'b0 || digit_wrap !== 4'b0000)
      $display("FAIL reset_async: count=%h carry=%b wrap=%b expected 0000/0/0000",
               count, carry, digit_wrap);
    else n_pass++;
    en = 1'b0;
    #2 reset = 1'b1;
    step();
    n_checks++;
    if (count !== 16'h0000 || carry !== 1'b0)
      $display("FAIL reset_hold: count=%h carry=%b expected 0000/0", count, carry);
    else n_pass++;
  endtask

  task automatic test_up_count();
    do_clear();
    up = 1'b1; en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k < 10) begin
        n_checks++;
        if (count !== 16'(k) || digit_wrap !== 4'b0000 || carry !== 1'b0)
          $display("FAIL up_step%0d: count=%h wrap=%b carry=%b expected %h/0000/0",
                   k, count, digit_wrap, carry, 16'(k));
        else n_pass++;
      end
    end
    en = 1'b0;
    n_checks++;
    if (count !== 16'h0010 || digit_wrap !== 4'b0001 || carry !== 1'b0)
      $display("FAIL up_10th: count=%h wrap=%b carry=%b expected 0010/0001/0",
               count, digit_wrap, carry);
    else n_pass++;
    step();
    n_checks++;
    if (count !== 16'h0010 || digit_wrap !== 4'b0000)
      $display("FAIL up_hold: count=%h wrap=%b expected 0010/0000", count, digit_wrap);
    else n_pass++;
  endtask

  task automatic test_full_wrap();
    up = 1'b1;
    do_load(16'h5959);
    n_checks++;
    if (tc !== 1'b1) $display("FAIL full_tc_before: tc=%b expected 1", tc);
    else n_pass++;
    en = 1'b1;
    step();
    en = 1'b0;
    n_checks++;
`ifdef COUNTER_SATURATE_EN
    if (count !== 16'h5959 || digit_wrap !== 4'b0000 || carry !== 1'b1)
      $display("FAIL full_wrap: count=%h wrap=%b carry=%b expected 5959/0000/1",
               count, digit_wrap, carry);
`else
    if (count !== 16'h0000 || digit_wrap !== 4'b1111 || carry !== 1'b1)
      $display("FAIL full_wrap: count=%h wrap=%b carry=%b expected 0000/1111/1",
               count, digit_wrap, carry);
`endif
    else n_pass++;
    step();
    n_checks++;
    if (digit_wrap !== 4'b0000 || carry !== 1'b0)
      $display("FAIL full_pulse_end: wrap=%b carry=%b expected 0000/0", digit_wrap, carry);
    else n_pass++;
  endtask

  task automatic test_down_wrap();
    do_clear();
    up = 1'b0;
    #1;
    n_checks++;
    if (tc !== 1'b1) $display("FAIL down_tc_before: tc=%b expected 1", tc);
    else n_pass++;
    en = 1'b1;
    step();
    en = 1'b0;
    n_checks++;
`ifdef COUNTER_SATURATE_EN
    if (count !== 16'h0000 || carry !== 1'b1 || tc !== 1'b1 || digit_wrap !== 4'b0000)
      $display("FAIL down_wrap: count=%h carry=%b tc=%b wrap=%b expected 0000/1/1/0000",
               count, carry, tc, digit_wrap);
`else
    if (count !== 16'h5959 || carry !== 1'b1 || tc !== 1'b0 || digit_wrap !== 4'b1111)
      $display("FAIL down_wrap: count=%h carry=%b tc=%b wrap=%b expected 5959/1/0/1111",
               count, carry, tc, digit_wrap);
`endif
    else n_pass++;
  endtask

  task automatic test_load_clamp();
    do_load(16'hFFFF);
    n_checks++;
    if (count !== 16'h5959) $display("FAIL clamp_ffff: count=%h expected 5959", count);
    else n_pass++;
    do_load(16'h7A3B);
    n_checks++;
    if (count !== 16'h5939) $display("FAIL clamp_mixed: count=%h expected 5939", count);
    else n_pass++;
    en = 1'b1; up = 1'b1;
    do_load(16'h0123);
    n_checks++;
    if (count !== 16'h0123 || digit_wrap !== 4'b0000 || carry !== 1'b0)
      $display("FAIL load_over_en: count=%h wrap=%b carry=%b expected 0123/0000/0",
               count, digit_wrap, carry);
    else n_pass++;
    clear = 1'b1; load = 1'b1; load_val = 16'h1234;
    step();
    clear = 1'b0; load = 1'b0; en = 1'b0;
    n_checks++;
    if (count !== 16'h0000) $display("FAIL clear_prio: count=%h expected 0000", count);
    else n_pass++;
  endtask

  task automatic test_direction();
    do_load(16'h0009);
    up = 1'b0; en = 1'b1;
    step();
    en = 1'b0;
    n_checks++;
    if (count !== 16'h0008 || digit_wrap !== 4'b0000)
      $display("FAIL dir_down: count=%h wrap=%b expected 0008/0000", count, digit_wrap);
    else n_pass++;
    do_load(16'h0010);
    en = 1'b1;
    step();
    en = 1'b0;
    n_checks++;
    if (count !== 16'h0009 || digit_wrap !== 4'b0001 || carry !== 1'b0)
      $display("FAIL dir_borrow: count=%h wrap=%b carry=%b expected 0009/0001/0",
               count, digit_wrap, carry);
    else n_pass++;
    up = 1'b1; en = 1'b1;
    step();
    en = 1'b0;
    n_checks++;
    if (count !== 16'h0010 || digit_wrap !== 4'b0001)
      $display("FAIL dir_up_again: count=%h wrap=%b expected 0010/0001", count, digit_wrap);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    up = 1'b1;
    do_load(16'h5958);
    en = 1'b1;
    step();
    n_checks++;
    if (count !== 16'h5959 || carry !== 1'b0 || digit_wrap !== 4'b0000)
      $display("FAIL b2b_1: count=%h carry=%b wrap=%b expected 5959/0/0000",
               count, carry, digit_wrap);
    else n_pass++;
    step();
    n_checks++;
`ifdef COUNTER_SATURATE_EN
    if (count !== 16'h5959 || carry !== 1'b1 || digit_wrap !== 4'b0000)
      $display("FAIL b2b_2: count=%h carry=%b wrap=%b expected 5959/1/0000",
               count, carry, digit_wrap);
`else
    if (count !== 16'h0000 || carry !== 1'b1 || digit_wrap !== 4'b1111)
      $display("FAIL b2b_2: count=%h carry=%b wrap=%b expected 0000/1/1111",
               count, carry, digit_wrap);
`endif
    else n_pass++;
    step();
    en = 1'b0;
    n_checks++;
`ifdef COUNTER_SATURATE_EN
    if (count !== 16'h5959 || carry !== 1'b1 || digit_wrap !== 4'b0000)
      $display("FAIL b2b_3: count=%h carry=%b wrap=%b expected 5959/1/0000",
               count, carry, digit_wrap);
`else
    if (count !== 16'h0001 || carry !== 1'b0 || digit_wrap !== 4'b0000)
      $display("FAIL b2b_3: count=%h carry=%b wrap=%b expected 0001/0/0000",
               count, carry, digit_wrap);
`endif
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_full_wrap();
    test_down_wrap();
    test_load_clamp();
    test_direction();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
